// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial transmitter slice that feeds the
//   deserializer: byte width, bits per serial frame and the transmitter
//   state encoding.
// ----------------------------------------------------------------------------
package serial_pkg;

  localparam int BYTE_W        = 8;
  localparam int BITS_PER_BYTE = 8;

  // IDLE  : waiting for a queued byte and a non-busy deserializer
  // SHIFT : emitting the eight bits of the loaded byte, MSB first
  // GAP   : enforced quiet time between consecutive bytes
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/serializador_tx_byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
//   Circular byte buffer sitting between the parallel handshake and the
//   serial shifter. Read/write pointers wrap naturally because DEPTH is a
//   power of two; the occupancy is kept as a separate registered level so
//   full and empty are unambiguous.
//
// Ports
//   clk_100KHz : clock, rising edge
//   reset      : asynchronous, active-low
//   i_push     : write i_data at the tail (ignored when full)
//   i_data     : byte to store
//   i_pop      : drop the head entry (ignored when empty)
//   o_head     : byte currently at the head, combinational
//   o_level    : registered occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk_100KHz,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_level
);

  import serial_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;

  logic w_doPush;
  logic w_doPop;

  // Requests that would overflow or underflow are silently dropped here so
  // the caller never corrupts the pointers.
  assign w_doPush = i_push & (r_level != FULL_LVL);
  assign w_doPop  = i_pop  & (r_level != '0);

  // Storage array carries no reset: an entry is only ever read after it has
  // been written, and the pointers/level are what define validity.
  always_ff @(posedge clk_100KHz) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
  // both pointers and leaves the level unchanged.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_level = r_level;

endmodule

// File: rtl/serializador_tx.sv
// ----------------------------------------------------------------------------
// serializador_tx
//   Transmitter stage in front of the deserializer. Parallel bytes arrive on
//   a valid/ready handshake, wait in a small FIFO, and are shifted out MSB
//   first as eight write-qualified serial bits. While the deserializer says
//   it is busy, the current bit is held back and resumes unchanged.
//
// Parameters
//   DEPTH : FIFO depth in bytes, power of two, at least 2
//   GAP   : idle cycles inserted after each byte, 0..15
//
// Ports
//   clk_100KHz    : sole clock, rising edge
//   reset         : asynchronous, active-low; clears everything
//   byte_in       : parallel byte
//   byte_valid    : byte_in is valid this cycle
//   byte_ready    : FIFO can take a byte (low while in reset)
//   des_status_in : deserializer busy flag; 1 = do not write
//   data_out      : serial data bit, registered
//   write_out     : serial bit strobe, registered
//   busy_out      : registered; transmitter active or FIFO not empty
//   level_out     : FIFO occupancy
//   sent_count    : bytes fully transmitted, modulo 256
// ----------------------------------------------------------------------------
module serializador_tx #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk_100KHz,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   des_status_in,
  output logic                   data_out,
  output logic                   write_out,
  output logic                   busy_out,
  output logic [$clog2(DEPTH):0] level_out,
  output logic [7:0]             sent_count
);

  import serial_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_BYTE - 1);
  // Only meaningful when GAP > 0; the GAP state is never entered otherwise.
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

  tx_state_t         r_state;
  tx_state_t         w_nextState;
  logic [BYTE_W-1:0] r_shreg;
  logic [BYTE_W-1:0] w_nextShreg;
  logic [2:0]        r_bitCnt;
  logic [2:0]        w_nextBitCnt;
  logic [3:0]        r_gapCnt;
  logic [3:0]        w_nextGapCnt;
  logic              r_dataOut;
  logic              w_nextDataOut;
  logic              r_writeOut;
  logic              w_nextWriteOut;
  logic [7:0]        r_sentCount;
  logic [7:0]        w_nextSentCount;
  logic              r_busy;
  logic              w_nextBusy;

  logic              w_push;
  logic              w_pop;
  logic [BYTE_W-1:0] w_head;
  logic [LW-1:0]     w_level;
  logic [LW-1:0]     w_nextLevel;

  // Ready depends only on the registered level, so a pop on the same edge
  // never opens a path from a full FIFO straight into the shifter.
  assign byte_ready = reset & (w_level != FULL_LVL);
  assign w_push     = byte_valid & byte_ready;

  byte_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .i_push     (w_push),
    .i_data     (byte_in),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_level    (w_level)
  );

  // Occupancy after this edge, used so busy_out lines up with level_out.
  assign w_nextLevel = w_level + LW'(w_push) - LW'(w_pop);

  // Next-state and datapath logic. The busy flag from the deserializer is
  // looked at on exactly the edge a bit would be registered, so a stall
  // suppresses that bit and leaves shreg/bit_cnt where they were.
  always_comb begin
    w_nextState     = r_state;
    w_nextShreg     = r_shreg;
    w_nextBitCnt    = r_bitCnt;
    w_nextGapCnt    = r_gapCnt;
    w_nextDataOut   = r_dataOut;
    w_nextWriteOut  = 1'b0;
    w_nextSentCount = r_sentCount;
    w_pop           = 1'b0;

    case (r_state)
      IDLE: begin
        if ((w_level != '0) && !des_status_in) begin
          w_pop        = 1'b1;
          w_nextShreg  = w_head;
          w_nextBitCnt = '0;
          w_nextState  = SHIFT;
        end
      end

      SHIFT: begin
        if (!des_status_in) begin
          w_nextWriteOut = 1'b1;
          w_nextDataOut  = r_shreg[BYTE_W-1];
          w_nextShreg    = {r_shreg[BYTE_W-2:0], 1'b0};
          w_nextBitCnt   = r_bitCnt + 3'(1);
          if (r_bitCnt == LAST_BIT) begin
            w_nextSentCount = r_sentCount + 8'(1);
            w_nextGapCnt    = '0;
            w_nextState     = (GAP == 0) ? IDLE : serial_pkg::GAP;
          end
        end
      end

      serial_pkg::GAP: begin
        if (r_gapCnt == GAP_LAST) begin
          w_nextState = IDLE;
        end else begin
          w_nextGapCnt = r_gapCnt + 4'(1);
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase

    w_nextBusy = (w_nextState != IDLE) || (w_nextLevel != '0);
  end

  // State register. Reset drops everything at once, including any byte
  // that was partway through the shifter.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bitCnt    <= '0;
      r_gapCnt    <= '0;
      r_dataOut   <= 1'b0;
      r_writeOut  <= 1'b0;
      r_sentCount <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_shreg     <= w_nextShreg;
      r_bitCnt    <= w_nextBitCnt;
      r_gapCnt    <= w_nextGapCnt;
      r_dataOut   <= w_nextDataOut;
      r_writeOut  <= w_nextWriteOut;
      r_sentCount <= w_nextSentCount;
      r_busy      <= w_nextBusy;
    end
  end

  assign data_out   = r_dataOut;
  assign write_out  = r_writeOut;
  assign busy_out   = r_busy;
  assign level_out  = w_level;
  assign sent_count = r_sentCount;

endmodule
